// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and elaboration helpers for the SRAM responder.
package dbus_sram_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  // Wide enough to hold LATENCY_MAX-1.
  localparam int CNT_W       = 4;

  function automatic bit latency_legal(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dbus_sram_responder_bram.sv
// Word-organised, byte-writable SRAM with registered synchronous read.
// The array itself is never reset; only the read register clears.
module dbus_sram_responder_bram
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  strobe_t       wen,
  input  logic [AW-1:0] idx,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH_WORDS];

  // Byte-lane writes on an enabled cycle; unselected lanes keep their value.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register samples the old word on the same edge as a write (read-before-write)
  // and holds until the next enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder in front of a byte-writable SRAM with fixed response latency.
// One request outstanding; acceptance only while idle.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no request pending; addr_ok follows dreq.valid
//   ST_WAIT | request accepted; counting down, data_ok when counter hits 0
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("dbus_sram_responder: LATENCY must be in 1..15");
  end
  if (!is_pow2(DEPTH_WORDS)) begin : g_bad_depth
    $error("dbus_sram_responder: DEPTH_WORDS must be a power of two");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             addr_ok;
  logic             data_ok;
  logic [AW-1:0]    idx;
  word_t            rdata;

  // Word index wraps modulo depth; byte offset, size and upper address bits don't matter.
  assign idx = dreq.addr[AW+1:2];

  logic unused_req_bits;
  assign unused_req_bits = ^{dreq.size, dreq.addr[31:AW+2], dreq.addr[1:0]};

  // State and latency down-counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and handshake decode. addr_ok is gated by resetn so that a
  // valid request held during reset is neither acknowledged nor written.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dreq.valid && resetn) begin
          addr_ok    = 1'b1;
          state_next = ST_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          data_ok    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  dbus_sram_responder_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bram (
    .clk  (clk),
    .rst_n(resetn),
    .en   (addr_ok),
    .wen  (dreq.strobe),
    .idx  (idx),
    .wdata(dreq.data),
    .rdata(rdata)
  );

  assign dresp.addr_ok = addr_ok;
  assign dresp.data_ok = data_ok;
  assign dresp.data    = rdata;

endmodule
